// File: rtl/alu_rr_sched.sv
// Two-requester scheduler sharing one 4-bit ALU (add/sub/shl/and), with a tagged response channel.
// Define ALU_SCHED_FIXED_PRIO_EN for fixed priority (requester 0 wins ties); default is round-robin.
module alu_rr_sched #(
    parameter int DATA_W = 4,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [DATA_W-1:0] req_a0,
    input  logic [DATA_W-1:0] req_b0,
    input  logic [1:0]        req_op0,
    input  logic [DATA_W-1:0] req_a1,
    input  logic [DATA_W-1:0] req_b1,
    input  logic [1:0]        req_op1,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_src,
    output logic              busy,
    output logic [CNT_W-1:0]  cnt0,
    output logic [CNT_W-1:0]  cnt1
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic [DATA_W-1:0] SHIFT_LIM = DATA_W'(DATA_W);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_SHL = 2'b10;
    localparam logic [1:0] OP_AND = 2'b11;

    logic [1:0]        state;
    logic [DATA_W-1:0] lat_a;
    logic [DATA_W-1:0] lat_b;
    logic [1:0]        lat_op;
    logic              lat_src;
    logic [1:0]        grant;
    logic [DATA_W-1:0] alu_y;

`ifdef ALU_SCHED_FIXED_PRIO_EN
    always_comb begin
        grant = '0;
        if (state == IDLE) begin
            if (req_valid[0]) begin
                grant = 2'b01;
            end else if (req_valid[1]) begin
                grant = 2'b10;
            end
        end
    end
`else
    logic last_grant;

    // On a tie the requester that did not win last time is served.
    always_comb begin
        grant = '0;
        if (state == IDLE) begin
            case (req_valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = last_grant ? 2'b01 : 2'b10;
                default: grant = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
        end else if (|grant) begin
            last_grant <= grant[1];
        end
    end
`endif

    assign req_ready = grant;

    always_comb begin
        alu_y = '0;
        case (lat_op)
            OP_ADD:  alu_y = lat_a + lat_b;
            OP_SUB:  alu_y = lat_a - lat_b;
            OP_SHL:  alu_y = (lat_b >= SHIFT_LIM) ? '0 : (lat_a << lat_b);
            OP_AND:  alu_y = lat_a & lat_b;
            default: alu_y = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            lat_a    <= '0;
            lat_b    <= '0;
            lat_op   <= '0;
            lat_src  <= 1'b0;
            rsp_data <= '0;
            rsp_src  <= 1'b0;
            cnt0     <= '0;
            cnt1     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|grant) begin
                        lat_a   <= grant[1] ? req_a1  : req_a0;
                        lat_b   <= grant[1] ? req_b1  : req_b0;
                        lat_op  <= grant[1] ? req_op1 : req_op0;
                        lat_src <= grant[1];
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_data <= alu_y;
                    rsp_src  <= lat_src;
                    state    <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        if (rsp_src) begin
                            cnt1 <= cnt1 + CNT_W'(1);
                        end else begin
                            cnt0 <= cnt0 + CNT_W'(1);
                        end
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);

endmodule
